mem_access_stage: RTL and testbench

//  Memory-access pipeline stage between execute and writeback; sole master of the data cache.

---
 rtl/mem_access_stage_pkg.sv | 29 ++
 rtl/mem_access_stage_if.sv | 47 ++++
 rtl/mem_access_stage_addr_check.sv | 30 +++
 rtl/mem_access_stage.sv | 123 ++++++++++++
 tb/tb_mem_access_stage.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: uop codes, fault codes, FSM states.
// Also used by the address checker, which a future fetch stage will reuse.
package mem_access_stage_pkg;

  localparam int DEF_OFFSET_W = 12;
  localparam int DEF_IDX_W    = 5;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_LDR = 5'd1;
  localparam logic [4:0] UOP_STR = 5'd2;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2
  } fault_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_t;

  function automatic logic is_mem_uop(input logic [4:0] uop);
    return (uop == UOP_LDR) || (uop == UOP_STR);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bus bundle around the memory-access stage: execute request, writeback response, data cache.
// master = the stage itself; slave = its surroundings (execute, writeback, cache).
interface mem_access_stage_if #(
  parameter int OFFSET_W = 12,
  parameter int IDX_W    = 5
);

  logic                req_valid;
  logic                req_ready;
  logic [4:0]          req_uop;
  logic [31:0]         req_base;
  logic [OFFSET_W-1:0] req_offset;
  logic [31:0]         req_store_data;
  logic [3:0]          req_rd;
  logic                req_wb_en;

  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_data;
  logic [3:0]          resp_rd;
  logic                resp_we;
  logic [1:0]          resp_fault;

  logic [IDX_W-1:0]    dc_addr;
  logic [31:0]         dc_data_in;
  logic [4:0]          dc_uop;
  logic [31:0]         dc_data_out;

  modport master (
    input  req_valid, req_uop, req_base, req_offset, req_store_data, req_rd, req_wb_en,
    output req_ready,
    output resp_valid, resp_data, resp_rd, resp_we, resp_fault,
    input  resp_ready,
    output dc_addr, dc_data_in, dc_uop,
    input  dc_data_out
  );

  modport slave (
    output req_valid, req_uop, req_base, req_offset, req_store_data, req_rd, req_wb_en,
    input  req_ready,
    input  resp_valid, resp_data, resp_rd, resp_we, resp_fault,
    output resp_ready,
    input  dc_addr, dc_data_in, dc_uop,
    output dc_data_out
  );

endinterface

// File: rtl/mem_access_stage_addr_check.sv
// Effective-address adder with word-index slice and alignment/range fault decode.
// Purely combinational so an instruction-fetch stage can share it.
module mem_addr_check
  import mem_access_stage_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic [31:0]         base,
  input  logic [OFFSET_W-1:0] offset,
  output logic [IDX_W-1:0]    idx,
  output fault_t              fault
);

  logic [31:0] ea;

  assign ea  = base + {{(32-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign idx = ea[IDX_W+1:2];

  // Misalignment wins over range when both apply.
  always_comb begin
    fault = FLT_NONE;
    if (ea[1:0] != 2'b00) begin
      fault = FLT_MISALIGN;
    end else if (ea[31:IDX_W+2] != '0) begin
      fault = FLT_RANGE;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one record in flight, drives the data cache for LDR/STR,
// passes non-memory results through and presents a writeback record with fault status.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_stage_if.master bus
);

  // state   | meaning
  // IDLE    | empty, ready for a record
  // ACCESS  | cache op driven (store commits on the falling edge)
  // CAPTURE | cache read data valid on dc_data_out
  // RESP    | writeback record presented, held until resp_ready

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic             ready;
  logic             accept;
  logic             req_is_mem;
  logic [IDX_W-1:0] idx;
  fault_t           fault;

  logic [4:0]       uop_q;
  logic [IDX_W-1:0] addr_q;
  logic [31:0]      sdata_q;
  logic [31:0]      data_q;
  logic [3:0]       rd_q;
  logic             we_q;
  fault_t           fault_q;

  mem_addr_check #(
    .OFFSET_W (OFFSET_W),
    .IDX_W    (IDX_W)
  ) u_addr_check (
    .base   (bus.req_base),
    .offset (bus.req_offset),
    .idx    (idx),
    .fault  (fault)
  );

  assign req_is_mem = is_mem_uop(bus.req_uop);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_ACCESS: begin
        state_nxt = (uop_q == UOP_LDR) ? ST_CAPTURE : ST_RESP;
      end
      ST_CAPTURE: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ready = bus.resp_ready;
        if (bus.resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    accept = ready & bus.req_valid;
    if (accept) begin
      state_nxt = (req_is_mem && (fault == FLT_NONE)) ? ST_ACCESS : ST_RESP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      uop_q   <= UOP_NOP;
      addr_q  <= '0;
      sdata_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= FLT_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        uop_q   <= bus.req_uop;
        addr_q  <= idx;
        sdata_q <= bus.req_store_data;
        rd_q    <= bus.req_rd;
        if (req_is_mem) begin
          data_q  <= '0;
          we_q    <= 1'b0;
          fault_q <= fault;
        end else begin
          data_q  <= bus.req_base;
          we_q    <= bus.req_wb_en;
          fault_q <= FLT_NONE;
        end
      end else if (state == ST_CAPTURE) begin
        // Read data is only valid for this one cycle; the cache zeroes it afterwards.
        data_q <= bus.dc_data_out;
        we_q   <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_we    = we_q;
  assign bus.resp_fault = fault_q;

  // Reset gates the cache op so no falling-edge store can slip through a reset cycle.
  assign bus.dc_uop     = (!reset && (state == ST_ACCESS)) ? uop_q : UOP_NOP;
  assign bus.dc_addr    = addr_q;
  assign bus.dc_data_in = sdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases plus randomized traffic,
// a behavioural data-cache model, and independent response / cache-op monitors.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        we;
    logic [1:0]  fault;
    bit          chk_data;
    bit          chk_rd;
    int          acc_cyc;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic [4:0]  uop;
    logic [4:0]  idx;
    logic [31:0] data;
  } dc_exp_t;

  resp_exp_t   resp_q[$];
  dc_exp_t     dc_q[$];
  logic [31:0] ref_mem [32];

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Data cache device: stores on the falling edge, read data registered on the rising edge.
  logic [31:0] cache_mem [32];
  bit          cache_init = 1'b0;

  always @(negedge clock) begin
    if (!cache_init) begin
      for (int i = 0; i < 32; i++) cache_mem[i] <= init_word(i);
      cache_init <= 1'b1;
    end else if (bus.dc_uop == UOP_STR) begin
      cache_mem[bus.dc_addr] <= bus.dc_data_in;
    end
  end

  always @(posedge clock)
    bus.dc_data_out <= (bus.dc_uop == UOP_LDR) ? cache_mem[bus.dc_addr] : 32'h0;

  bit rr_random = 1'b0;
  bit rr_force  = 1'b1;

  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.resp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_force;
    end
  end

  // Reference model: architectural effect of one accepted record.
  function automatic void predict(input logic [4:0] uop, input logic [31:0] base,
                                  input logic [11:0] off, input logic [31:0] sd,
                                  input logic [3:0] rd, input logic wb, input int acc);
    logic [31:0] ea;
    int          widx;
    resp_exp_t   r;
    dc_exp_t     d;
    ea         = base + {{20{off[11]}}, off};
    widx       = int'(ea >> 2);
    r.acc_cyc  = acc;
    r.rd       = rd;
    r.chk_rd   = 1'b1;
    r.chk_data = 1'b1;
    r.fault    = 2'd0;
    if (uop == UOP_LDR || uop == UOP_STR) begin
      if (ea % 4 != 0)      r.fault = 2'd1;
      else if (ea >= 128)   r.fault = 2'd2;
      if (r.fault != 2'd0) begin
        r.data = 32'h0; r.we = 1'b0; r.lat = 1; r.chk_rd = 1'b0;
      end else if (uop == UOP_LDR) begin
        r.data = ref_mem[widx]; r.we = 1'b1; r.lat = 3;
        d.uop = UOP_LDR; d.idx = 5'(widx); d.data = 32'h0;
        dc_q.push_back(d);
      end else begin
        ref_mem[widx] = sd;
        r.data = 32'h0; r.we = 1'b0; r.lat = 2; r.chk_data = 1'b0; r.chk_rd = 1'b0;
        d.uop = UOP_STR; d.idx = 5'(widx); d.data = sd;
        dc_q.push_back(d);
      end
    end else begin
      r.data = base; r.we = wb; r.lat = 1;
    end
    resp_q.push_back(r);
  endfunction

  task automatic issue(input logic [4:0] uop, input logic [31:0] base, input logic [11:0] off,
                       input logic [31:0] sd, input logic [3:0] rd, input logic wb,
                       input bit model, output int waited);
    bit acc;
    @(negedge clock);
    bus.req_uop        = uop;
    bus.req_base       = base;
    bus.req_offset     = off;
    bus.req_store_data = sd;
    bus.req_rd         = rd;
    bus.req_wb_en      = wb;
    bus.req_valid      = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 200) begin
      #4;
      if (bus.req_ready === 1'b1) acc = 1'b1;
      else begin
        @(negedge clock);
        waited++;
      end
    end
    if (!acc) begin
      errors++; checks++;
      $display("FAIL accept_timeout: request never accepted, uop %0d", uop);
    end else if (model) begin
      predict(uop, base, off, sd, rd, wb, cyc);
    end
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Response monitor: latency on first presentation, stability while stalled, contents on handshake.
  bit          seen_first = 1'b0;
  bit          held       = 1'b0;
  logic [31:0] h_data;
  logic [3:0]  h_rd;
  logic        h_we;
  logic [1:0]  h_fault;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      seen_first = 1'b0;
      held       = 1'b0;
    end else if (bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL resp_unexpected: record data %h with nothing outstanding", bus.resp_data);
      end else begin
        if (!seen_first) begin
          chk("latency", 32'(cyc - resp_q[0].acc_cyc), 32'(resp_q[0].lat));
          seen_first = 1'b1;
        end
        if (held) begin
          chk("stall_data",  bus.resp_data, h_data);
          chk("stall_rd",    32'(bus.resp_rd), 32'(h_rd));
          chk("stall_we",    32'(bus.resp_we), 32'(h_we));
          chk("stall_fault", 32'(bus.resp_fault), 32'(h_fault));
        end
        if (bus.resp_ready === 1'b1) begin
          resp_exp_t e;
          e = resp_q.pop_front();
          chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
          chk("resp_we", 32'(bus.resp_we), 32'(e.we));
          if (e.chk_data) chk("resp_data", bus.resp_data, e.data);
          if (e.chk_rd)   chk("resp_rd", 32'(bus.resp_rd), 32'(e.rd));
          seen_first = 1'b0;
          held       = 1'b0;
        end else begin
          held = 1'b1;
          h_data = bus.resp_data; h_rd = bus.resp_rd; h_we = bus.resp_we; h_fault = bus.resp_fault;
        end
      end
    end
  end

  // Cache-op monitor: every non-NOP cycle must match the next expected cache access.
  initial forever begin
    @(negedge clock);
    if (bus.dc_uop !== UOP_NOP) begin
      if (dc_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL dc_unexpected: uop %0d at index %0d, none expected", bus.dc_uop, bus.dc_addr);
      end else begin
        dc_exp_t d;
        d = dc_q.pop_front();
        chk("dc_uop", 32'(bus.dc_uop), 32'(d.uop));
        chk("dc_addr", 32'(bus.dc_addr), 32'(d.idx));
        if (d.uop == UOP_STR) chk("dc_data_in", bus.dc_data_in, d.data);
      end
    end
  end

  task automatic drain(input string nm);
    for (int i = 0; i < 500 && resp_q.size() != 0; i++) @(negedge clock);
    chk(nm, 32'(resp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    int kind;
    int o;
    int idx;
    logic [4:0]  u;
    logic [31:0] b;
    logic [11:0] f;

    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0; bus.req_uop = UOP_NOP; bus.req_base = '0; bus.req_offset = '0;
    bus.req_store_data = '0; bus.req_rd = '0; bus.req_wb_en = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_dc_uop", 32'(bus.dc_uop), 32'(UOP_NOP));
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("rst_resp_we", 32'(bus.resp_we), 32'd0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_dc_addr", 32'(bus.dc_addr), 32'd0);
    chk("rst_dc_data_in", bus.dc_data_in, 32'h0);
    reset = 1'b0;

    issue(UOP_STR, 32'h10, 12'h004, 32'hDEADBEEF, 4'd0, 1'b0, 1'b1, w);
    issue(UOP_LDR, 32'h18, 12'hFFC, 32'h0, 4'd3, 1'b0, 1'b1, w);
    issue(UOP_LDR, 32'h02, 12'h000, 32'h0, 4'd1, 1'b0, 1'b1, w);
    issue(UOP_LDR, 32'h80, 12'h000, 32'h0, 4'd2, 1'b0, 1'b1, w);
    issue(UOP_LDR, 32'h7E, 12'h000, 32'h0, 4'd4, 1'b0, 1'b1, w);
    issue(UOP_STR, 32'h82, 12'h000, 32'h1, 4'd4, 1'b0, 1'b1, w);
    issue(5'd7,    32'h1234, 12'h000, 32'h0, 4'd9, 1'b1, 1'b1, w);
    drain("drain_directed");

    // Backpressure on a load, then release together with a new request.
    rr_force = 1'b0;
    issue(UOP_LDR, 32'h14, 12'h000, 32'h0, 4'd5, 1'b0, 1'b1, w);
    for (int i = 0; i < 20 && bus.resp_valid !== 1'b1; i++) @(negedge clock);
    chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
    end
    rr_force = 1'b1;
    issue(5'd12, 32'hCAFE_0001, 12'h000, 32'h0, 4'd6, 1'b1, 1'b1, w);
    chk("bp_no_bubble", 32'(w), 32'd0);
    drain("drain_bp");

    // Reset lands in the store's ACCESS cycle: the store must never reach the cache.
    issue(UOP_STR, 32'h1C, 12'h000, 32'hA5A5A5A5, 4'd0, 1'b0, 1'b0, w);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_dc_uop", 32'(bus.dc_uop), 32'(UOP_NOP));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    issue(UOP_LDR, 32'h1C, 12'h000, 32'h0, 4'd7, 1'b0, 1'b1, w);
    drain("drain_reset");

    rr_random = 1'b1;
    for (int n = 0; n < 160; n++) begin
      kind = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, 31));
      o    = int'($urandom_range(0, 32)) - 16;
      f    = 12'(o * 4);
      b    = 32'(idx * 4 - o * 4);
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom;
        f = 12'($urandom);
      end
      if (kind < 4)      u = UOP_LDR;
      else if (kind < 7) u = UOP_STR;
      else if (kind == 9) u = UOP_NOP;
      else               u = 5'($urandom_range(3, 31));
      issue(u, b, f, $urandom, 4'($urandom), 1'($urandom), 1'b1, w);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain("drain_random");
    chk("dc_queue_empty", 32'(dc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
